// File: rtl/fc_if.sv
// fc_if: weight/bias load ports, feature input handshake and class result handshake of fc_classifier.
interface fc_if #(
    parameter int FAN_IN  = 960,
    parameter int N_CLASS = 10,
    parameter int BIAS_W  = 8,
    parameter int ACC_W   = 17
);
    logic                     w_wr_en;
    logic [3:0]               w_wr_class;
    logic [9:0]               w_wr_idx;
    logic                     w_wr_bit;
    logic                     b_wr_en;
    logic [3:0]               b_wr_class;
    logic [BIAS_W-1:0]        b_wr_data;
    logic                     feat_valid;
    logic                     feat_ready;
    logic [FAN_IN-1:0]        feat;
    logic                     class_out_valid;
    logic                     class_out_ready;
    logic [3:0]               class_out;
    logic [N_CLASS*ACC_W-1:0] fc_out;

    modport master (
        output w_wr_en, w_wr_class, w_wr_idx, w_wr_bit, b_wr_en, b_wr_class, b_wr_data,
        output feat_valid, feat, class_out_ready,
        input  feat_ready, class_out_valid, class_out, fc_out
    );
    modport slave (
        input  w_wr_en, w_wr_class, w_wr_idx, w_wr_bit, b_wr_en, b_wr_class, b_wr_data,
        input  feat_valid, feat, class_out_ready,
        output feat_ready, class_out_valid, class_out, fc_out
    );
endinterface

// File: rtl/fc_classifier.sv
// fc_classifier: binary XNOR-popcount fully-connected layer with signed bias and arg-max.
// Popcount is registered one stage ahead of the accumulator, which adds one cycle after the last chunk.
module fc_classifier #(
    parameter int FAN_IN  = 960,
    parameter int N_CLASS = 10,
    parameter int CHUNK   = 64,
    parameter int BIAS_W  = 8,
    parameter int ACC_W   = 17
) (
    input logic clk,
    input logic rst_n,
    fc_if.slave bus
);
    localparam int N_CHUNK = FAN_IN / CHUNK;
    localparam int KW      = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
    localparam int PW      = $clog2(CHUNK + 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
    state_t r_state, w_next;

    logic [FAN_IN-1:0]        r_w [N_CLASS];
    logic [BIAS_W-1:0]        r_bias [N_CLASS];
    logic [FAN_IN-1:0]        r_feat;
    logic [3:0]               r_c, r_pc_c, r_cls;
    logic [KW-1:0]            r_k;
    logic                     r_iss, r_pc_v, r_pc_last;
    logic [PW-1:0]            r_pc, w_pc;
    logic [CHUNK-1:0]         w_x;
    logic signed [ACC_W-1:0]  r_acc, r_best, w_sum, w_score;
    logic [N_CLASS*ACC_W-1:0] r_fc;
    logic                     w_accept, w_wr_ok, w_b_ok, w_last_k;

    assign w_accept = r_state == IDLE && bus.feat_valid;
    assign w_wr_ok  = r_state == IDLE && bus.w_wr_en && {1'b0, bus.w_wr_class} < 5'(N_CLASS)
                      && {1'b0, bus.w_wr_idx} < 11'(FAN_IN);
    assign w_b_ok   = r_state == IDLE && bus.b_wr_en && {1'b0, bus.b_wr_class} < 5'(N_CLASS);
    assign w_last_k = r_k == KW'(N_CHUNK - 1);
    assign w_x      = ~(r_feat[int'(r_k)*CHUNK +: CHUNK] ^ r_w[r_c][int'(r_k)*CHUNK +: CHUNK]);
    assign w_sum    = r_acc + ACC_W'(r_pc);
    assign w_score  = (w_sum <<< 1) - ACC_W'(FAN_IN) + ACC_W'(signed'(r_bias[r_pc_c]));

    always_comb begin
        w_pc = '0;
        for (int i = 0; i < CHUNK; i++) w_pc = w_pc + PW'(w_x[i]);
    end

    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE && bus.feat_valid) ? COMPUTE :
                 (r_state == COMPUTE && r_pc_v && r_pc_last && r_pc_c == 4'(N_CLASS - 1)) ? DONE :
                 (r_state == DONE && bus.class_out_ready) ? IDLE : r_state;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;

    // Weight memory deliberately has no reset so it survives rst_n.
    always_ff @(posedge clk)
        if (w_wr_ok) r_w[bus.w_wr_class][bus.w_wr_idx] <= bus.w_wr_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_feat    <= '0;
            r_c       <= '0;
            r_k       <= '0;
            r_iss     <= 1'b0;
            r_pc_v    <= 1'b0;
            r_pc_last <= 1'b0;
            r_pc      <= '0;
            r_pc_c    <= '0;
            r_acc     <= '0;
            r_best    <= '0;
            r_cls     <= '0;
            r_fc      <= '0;
            for (int i = 0; i < N_CLASS; i++) r_bias[i] <= '0;
        end else begin
            if (w_b_ok) r_bias[bus.b_wr_class] <= bus.b_wr_data;
            if (w_accept) begin
                r_feat <= bus.feat;
                r_c    <= '0;
                r_k    <= '0;
                r_acc  <= '0;
                r_best <= '0;
                r_iss  <= 1'b1;
                r_pc_v <= 1'b0;
            end
            if (r_state == COMPUTE) begin
                r_pc_v    <= r_iss;
                r_pc      <= w_pc;
                r_pc_c    <= r_c;
                r_pc_last <= w_last_k;
                if (r_iss) begin
                    r_k <= w_last_k ? '0 : r_k + 1'b1;
                    if (w_last_k && r_c == 4'(N_CLASS - 1)) r_iss <= 1'b0;
                    else if (w_last_k) r_c <= r_c + 1'b1;
                end
                if (r_pc_v) begin
                    r_acc <= r_pc_last ? '0 : w_sum;
                    if (r_pc_last) r_fc[int'(r_pc_c)*ACC_W +: ACC_W] <= w_score;
                    // Strict compare so ties keep the lowest class index.
                    if (r_pc_last && (r_pc_c == '0 || w_score > r_best)) begin
                        r_best <= w_score;
                        r_cls  <= r_pc_c;
                    end
                end
            end
        end
    end

    assign bus.feat_ready      = r_state == IDLE;
    assign bus.class_out_valid = r_state == DONE;
    assign bus.class_out       = r_cls;
    assign bus.fc_out          = r_fc;
endmodule

// File: tb/tb_fc_classifier.sv
// tb_fc_classifier: directed scenario tests of fc_classifier with hand-computed scores.
module tb_fc_classifier;
    localparam int FAN_IN  = 960;
    localparam int N_CLASS = 10;
    localparam int ACC_W   = 17;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [FAN_IN-1:0] pat;

    fc_if bus ();
    fc_classifier dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic int score(input int c);
        logic signed [ACC_W-1:0] s;
        s = bus.fc_out[c*ACC_W +: ACC_W];
        return int'(s);
    endfunction

    task automatic idle_bus();
        bus.w_wr_en = 0; bus.w_wr_class = 0; bus.w_wr_idx = 0; bus.w_wr_bit = 0;
        bus.b_wr_en = 0; bus.b_wr_class = 0; bus.b_wr_data = 0;
        bus.feat_valid = 0; bus.feat = '0; bus.class_out_ready = 0;
    endtask

    task automatic load_weights(input logic [FAN_IN-1:0] row7, input logic [FAN_IN-1:0] rest);
        for (int c = 0; c < N_CLASS; c++)
            for (int i = 0; i < FAN_IN; i++) begin
                @(negedge clk);
                bus.w_wr_en = 1; bus.w_wr_class = 4'(c); bus.w_wr_idx = 10'(i);
                bus.w_wr_bit = (c == 7) ? row7[i] : rest[i];
            end
        @(negedge clk);
        bus.w_wr_en = 0;
    endtask

    task automatic set_bias(input int c, input logic [7:0] d);
        @(negedge clk);
        bus.b_wr_en = 1; bus.b_wr_class = 4'(c); bus.b_wr_data = d;
        @(negedge clk);
        bus.b_wr_en = 0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (n < 300 && bus.class_out_valid !== 1'b1) begin
            @(posedge clk); n++; #1;
        end
    endtask

    task automatic run_inf(input logic [FAN_IN-1:0] f, output int n);
        @(negedge clk);
        bus.feat = f; bus.feat_valid = 1;
        @(posedge clk); #1 bus.feat_valid = 0;
        wait_valid(n);
    endtask

    task automatic ack();
        @(negedge clk);
        bus.class_out_ready = 1;
        @(posedge clk); #1 bus.class_out_ready = 0;
    endtask

    task automatic test_reset();
        idle_bus();
        rst_n = 0;
        repeat (3) @(negedge clk);
        checks++; if (bus.feat_ready !== 1'b1) begin failures++; $display("FAIL reset feat_ready got %0d exp 1", bus.feat_ready); end
        checks++; if (bus.class_out_valid !== 1'b0) begin failures++; $display("FAIL reset valid got %0d exp 0", bus.class_out_valid); end
        checks++; if (bus.class_out !== 4'd0) begin failures++; $display("FAIL reset class_out got %0d exp 0", bus.class_out); end
        checks++; if (bus.fc_out !== '0) begin failures++; $display("FAIL reset fc_out got nonzero exp 0"); end
        rst_n = 1;
    endtask

    task automatic test_all_ones();
        logic [FAN_IN-1:0] ones;
        int n;
        ones = '1;
        load_weights(ones, ones);
        run_inf(ones, n);
        checks++; if (n !== 151) begin failures++; $display("FAIL ones latency got %0d exp 151", n); end
        checks++; if (bus.class_out !== 4'd0) begin failures++; $display("FAIL ones class_out got %0d exp 0", bus.class_out); end
        for (int c = 0; c < N_CLASS; c++) begin
            checks++; if (score(c) !== 960) begin failures++; $display("FAIL ones score%0d got %0d exp 960", c, score(c)); end
        end
        ack();
        checks++; if (bus.feat_ready !== 1'b1) begin failures++; $display("FAIL ones post_ack feat_ready got %0d exp 1", bus.feat_ready); end
    endtask

    task automatic test_bias_winner();
        int n;
        set_bias(3, 8'd5);
        run_inf('0, n);
        for (int c = 0; c < N_CLASS; c++) begin
            checks++; if (score(c) !== ((c == 3) ? -955 : -960)) begin failures++; $display("FAIL bias score%0d got %0d exp %0d", c, score(c), (c == 3) ? -955 : -960); end
        end
        checks++; if (bus.class_out !== 4'd3) begin failures++; $display("FAIL bias class_out got %0d exp 3", bus.class_out); end
        ack();
    endtask

    task automatic test_pattern();
        int n;
        load_weights(pat, ~pat);
        set_bias(3, 8'd0);
        set_bias(2, 8'd127);
        run_inf(pat, n);
        for (int c = 0; c < N_CLASS; c++) begin
            checks++; if (score(c) !== ((c == 7) ? 960 : (c == 2) ? -833 : -960)) begin failures++; $display("FAIL pattern score%0d got %0d exp %0d", c, score(c), (c == 7) ? 960 : (c == 2) ? -833 : -960); end
        end
        checks++; if (bus.class_out !== 4'd7) begin failures++; $display("FAIL pattern class_out got %0d exp 7", bus.class_out); end
        ack();
    endtask

    task automatic test_backpressure();
        int n;
        int bad;
        logic [N_CLASS*ACC_W-1:0] saved;
        run_inf(pat, n);
        saved = bus.fc_out;
        bad = 0;
        @(negedge clk);
        bus.feat = ~pat; bus.feat_valid = 1;
        repeat (20) begin
            @(negedge clk);
            if (bus.class_out !== 4'd7 || bus.fc_out !== saved || bus.feat_ready !== 1'b0 || bus.class_out_valid !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL backpressure unstable_cycles got %0d exp 0", bad); end
        bus.class_out_ready = 1;
        @(posedge clk); #1 bus.class_out_ready = 0;
        checks++; if (bus.feat_ready !== 1'b1) begin failures++; $display("FAIL bp handshake feat_ready got %0d exp 1", bus.feat_ready); end
        checks++; if (bus.class_out_valid !== 1'b0) begin failures++; $display("FAIL bp handshake valid got %0d exp 0", bus.class_out_valid); end
        @(posedge clk); #1 bus.feat_valid = 0;
        checks++; if (bus.feat_ready !== 1'b0) begin failures++; $display("FAIL bp accept feat_ready got %0d exp 0", bus.feat_ready); end
        wait_valid(n);
        checks++; if (n !== 151) begin failures++; $display("FAIL bp latency got %0d exp 151", n); end
        checks++; if (bus.class_out !== 4'd2) begin failures++; $display("FAIL bp class_out got %0d exp 2", bus.class_out); end
        checks++; if (score(2) !== 1087) begin failures++; $display("FAIL bp score2 got %0d exp 1087", score(2)); end
        checks++; if (score(7) !== -960) begin failures++; $display("FAIL bp score7 got %0d exp -960", score(7)); end
        ack();
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        bus.feat = pat; bus.feat_valid = 1;
        @(posedge clk); #1 bus.feat_valid = 0;
        repeat (70) @(posedge clk);
        @(negedge clk);
        rst_n = 0;
        #1;
        checks++; if (bus.feat_ready !== 1'b1) begin failures++; $display("FAIL midrst feat_ready got %0d exp 1", bus.feat_ready); end
        checks++; if (bus.class_out_valid !== 1'b0) begin failures++; $display("FAIL midrst valid got %0d exp 0", bus.class_out_valid); end
        checks++; if (bus.class_out !== 4'd0) begin failures++; $display("FAIL midrst class_out got %0d exp 0", bus.class_out); end
        checks++; if (bus.fc_out !== '0) begin failures++; $display("FAIL midrst fc_out got nonzero exp 0"); end
        @(negedge clk);
        rst_n = 1;
        set_bias(2, 8'd127);
        run_inf(pat, n);
        checks++; if (bus.class_out !== 4'd7) begin failures++; $display("FAIL midrst rerun class_out got %0d exp 7", bus.class_out); end
        checks++; if (score(7) !== 960) begin failures++; $display("FAIL midrst rerun score7 got %0d exp 960", score(7)); end
        checks++; if (score(2) !== -833) begin failures++; $display("FAIL midrst rerun score2 got %0d exp -833", score(2)); end
        ack();
    endtask

    task automatic test_drop_writes();
        int n;
        @(negedge clk);
        bus.feat = pat; bus.feat_valid = 1;
        @(posedge clk); #1 bus.feat_valid = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            bus.w_wr_en = 1; bus.w_wr_class = 4'd7; bus.w_wr_idx = 10'(i); bus.w_wr_bit = 0;
            bus.b_wr_en = 1; bus.b_wr_class = 4'd7; bus.b_wr_data = 8'h9C;
        end
        @(negedge clk);
        bus.w_wr_en = 0; bus.b_wr_en = 0;
        wait_valid(n);
        checks++; if (score(7) !== 960) begin failures++; $display("FAIL drop inflight score7 got %0d exp 960", score(7)); end
        ack();
        run_inf(pat, n);
        checks++; if (n !== 151) begin failures++; $display("FAIL drop repeat latency got %0d exp 151", n); end
        checks++; if (score(7) !== 960) begin failures++; $display("FAIL drop repeat score7 got %0d exp 960", score(7)); end
        checks++; if (bus.class_out !== 4'd7) begin failures++; $display("FAIL drop repeat class_out got %0d exp 7", bus.class_out); end
        ack();
    endtask

    initial begin
        pat = {480{2'b10}};
        test_reset();
        test_all_ones();
        test_bias_winner();
        test_pattern();
        test_backpressure();
        test_reset_mid();
        test_drop_writes();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
